// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral exposing a small register file. Write frames commit when nCS rises.
// Read frames shift the addressed register out on CIPO.
module spi_regfile_peripheral #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 err_cnt
);

    localparam int CMD_W   = ADDR_W + 1;
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_ADDR_CNT  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] FIRST_DATA_CNT = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] LAST_DATA_CNT  = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] { IDLE, CMD, DATA, HOLD } state_t;

    state_t            state;
    logic [2:0]        sclk_sync;
    logic [2:0]        ncs_sync;
    logic              copi_s1;
    logic              copi_s2;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              ncs_rise;
    logic              ncs_fall;
    logic              ncs_low;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CMD_W-1:0]  cmd_sr;
    logic [CMD_W-1:0]  cmd_next;
    logic [DATA_W-1:0] data_sr;
    logic [DATA_W-1:0] rd_sr;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic              addr_valid;
    logic              commit_pend;
    logic [ADDR_W-1:0] commit_addr;

    // Index 0 is the first synchroniser flop; index 2 is the edge-detect delay flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 3'b000;
            ncs_sync  <= 3'b111;
            copi_s1   <= 1'b0;
            copi_s2   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SCLK};
            ncs_sync  <= {ncs_sync[1:0], nCS};
            copi_s1   <= COPI;
            copi_s2   <= copi_s1;
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
    assign ncs_rise   = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall   = ~ncs_sync[1] & ncs_sync[2];
    assign ncs_low    = ~ncs_sync[1];

    assign cmd_next   = (cmd_sr << 1) | CMD_W'(copi_s2);
    assign cmd_rw     = cmd_sr[ADDR_W];
    assign cmd_addr   = cmd_sr[ADDR_W-1:0];
    assign addr_valid = int'(cmd_addr) < NUM_REGS;
    assign rd_shift   = rd_sr << 1;

    // The read word is looked up with the address that is completing on this very edge.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cmd_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd_sr      <= '0;
            data_sr     <= '0;
            rd_sr       <= '0;
            CIPO        <= 1'b0;
            cipo_oe     <= 1'b0;
            err_cnt     <= 8'd0;
            commit_pend <= 1'b0;
            commit_addr <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            commit_pend <= 1'b0;
            if (ncs_rise) begin
                state   <= IDLE;
                CIPO    <= 1'b0;
                cipo_oe <= 1'b0;
                if (state == HOLD) begin
                    if (cmd_rw) begin
                        if (addr_valid) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (cmd_addr == ADDR_W'(i)) begin
                                    regs[i] <= data_sr;
                                end
                            end
                            commit_pend <= 1'b1;
                            commit_addr <= cmd_addr;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end else if (state == CMD || state == DATA) begin
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (ncs_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                            cmd_sr  <= '0;
                            data_sr <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise && ncs_low) begin
                            cmd_sr  <= cmd_next;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_ADDR_CNT) begin
                                state <= DATA;
                                if (!cmd_next[ADDR_W]) begin
                                    rd_sr   <= rd_word;
                                    CIPO    <= rd_word[DATA_W-1];
                                    cipo_oe <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise && ncs_low) begin
                            data_sr <= (data_sr << 1) | DATA_W'(copi_s2);
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_DATA_CNT) begin
                                state   <= HOLD;
                                CIPO    <= 1'b0;
                                cipo_oe <= 1'b0;
                            end
                        end else if (sclk_fall && cipo_oe && bit_cnt != FIRST_DATA_CNT) begin
                            // The falling edge right after the last address bit opens data slot 0.
                            // The MSB is already on CIPO, so that edge must not shift.
                            rd_sr <= rd_shift;
                            CIPO  <= rd_shift[DATA_W-1];
                        end
                    end
                    HOLD: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit_pend;
            if (commit_pend) begin
                wr_addr <= commit_addr;
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed plus random SPI frames for spi_regfile_peripheral.
// The reference is an array/counter model of the register file.
module tb_spi_regfile_peripheral;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int FRAME_W  = 1 + ADDR_W + DATA_W;
    localparam int HALF     = 8;

    logic                       clk;
    logic                       rst;
    logic                       SCLK;
    logic                       COPI;
    logic                       nCS;
    logic                       CIPO;
    logic                       cipo_oe;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic [7:0]                 err_cnt;

    int   vec_cnt     = 0;
    int   miss_cnt    = 0;
    int   strobe_seen = 0;
    int   long_pulse  = 0;
    logic prev_strobe = 1'b0;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    int                m_err;
    int                m_strobes;
    logic [ADDR_W-1:0] m_wr_addr;

    spi_regfile_peripheral #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS),
        .CIPO      (CIPO),
        .cipo_oe   (cipo_oe),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts strobe pulses and any pulse lasting longer than one clock.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) strobe_seen++;
        if (wr_strobe === 1'b1 && prev_strobe === 1'b1) long_pulse++;
        prev_strobe = wr_strobe;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_cnt++;
        assert (observed === expected) else begin
            miss_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_regs[i];
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] addr);
        int a;
        a = int'(addr);
        if (a < NUM_REGS) return m_regs[a];
        return '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_err     = 0;
        m_wr_addr = '0;
    endtask

    task automatic verifyState(input string tag);
        checkOutput({tag, "_regs"},    64'(regs_flat),   64'(model_flat()));
        checkOutput({tag, "_err"},     64'(err_cnt),     64'(m_err));
        checkOutput({tag, "_wraddr"},  64'(wr_addr),     64'(m_wr_addr));
        checkOutput({tag, "_strobes"}, 64'(strobe_seen), 64'(m_strobes));
        checkOutput({tag, "_longpls"}, 64'(long_pulse),  64'd0);
        checkOutput({tag, "_oe"},      64'(cipo_oe),     64'd0);
        checkOutput({tag, "_cipo"},    64'(CIPO),        64'd0);
    endtask

    // Send nbits of a frame (extra bits are random); optionally close it and update the model.
    task automatic applyStimulus(input logic rw, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input int nbits, input bit raise_cs);
        logic [FRAME_W-1:0] frame;
        logic [DATA_W-1:0]  rd_exp;
        bit                 full;
        bit                 valid_wr;
        frame    = {rw, addr, data};
        rd_exp   = model_read(addr);
        full     = nbits >= FRAME_W;
        valid_wr = full && rw && (int'(addr) < NUM_REGS);
        @(negedge clk);
        SCLK = 1'b0;
        nCS  = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            COPI = (b < FRAME_W) ? frame[FRAME_W-1-b] : 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            if (!rw && b >= 1 + ADDR_W && b < FRAME_W) begin
                checkOutput("cipo_oe_rd", 64'(cipo_oe), 64'd1);
                checkOutput("cipo_bit",   64'(CIPO),    64'(rd_exp[FRAME_W-1-b]));
            end else begin
                checkOutput("cipo_oe_off", 64'(cipo_oe), 64'd0);
                checkOutput("cipo_quiet",  64'(CIPO),    64'd0);
            end
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        if (raise_cs) begin
            repeat (HALF) @(negedge clk);
            nCS = 1'b1;
            if (valid_wr) begin
                repeat (3) @(negedge clk);
                checkOutput("commit_reg",   64'(regs_flat[int'(addr)*DATA_W +: DATA_W]), 64'(data));
                checkOutput("strobe_early", 64'(wr_strobe), 64'd0);
                @(negedge clk);
                checkOutput("strobe_pulse", 64'(wr_strobe), 64'd1);
                checkOutput("strobe_addr",  64'(wr_addr),   64'(addr));
                @(negedge clk);
                checkOutput("strobe_end",   64'(wr_strobe), 64'd0);
            end
            if (!full || (rw && !valid_wr)) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end else if (valid_wr) begin
                m_regs[int'(addr)] = data;
                m_strobes++;
                m_wr_addr = addr;
            end
            repeat (8) @(negedge clk);
            verifyState("frame");
        end
    endtask

    logic              rw_r;
    logic [ADDR_W-1:0] a_r;
    logic [DATA_W-1:0] d_r;
    int                nb;
    int                kind;

    initial begin
        rst  = 1'b1;
        SCLK = 1'b0;
        COPI = 1'b0;
        nCS  = 1'b1;
        m_strobes = 0;
        model_reset();
        repeat (3) @(negedge clk);
        verifyState("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] directed frames");
        applyStimulus(1'b1, 7'd2, 8'hA5, FRAME_W, 1'b1);
        applyStimulus(1'b0, 7'd2, 8'h00, FRAME_W, 1'b1);
        applyStimulus(1'b1, 7'd5, 8'hFF, FRAME_W, 1'b1);
        applyStimulus(1'b0, 7'd6, 8'h00, FRAME_W, 1'b1);
        applyStimulus(1'b1, 7'd1, 8'h3C, 10, 1'b1);
        applyStimulus(1'b1, 7'd0, 8'h81, FRAME_W + 4, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 7'd3, 8'h55, 9, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        verifyState("reset_mid");
        nCS  = 1'b1;
        SCLK = 1'b0;
        COPI = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 7'd4, 8'h7E, FRAME_W, 1'b1);
        checkOutput("only_reg4", 64'(regs_flat), 64'h7E_00_00_00_00);

        $display("[TB] random frames");
        for (int n = 0; n < 30; n++) begin
            rw_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a_r = 7'($urandom_range(0, 127));
            else                           a_r = 7'($urandom_range(0, NUM_REGS + 1));
            d_r  = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 9);
            if (kind < 2)       nb = $urandom_range(1, FRAME_W - 1);
            else if (kind == 2) nb = FRAME_W + $urandom_range(1, 4);
            else                nb = FRAME_W;
            applyStimulus(rw_r, a_r, d_r, nb, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
